// File: rtl/product_accumulator.sv
// Accumulates a programmed number of unsigned products from a valid/ready stream
// and presents the wrapped sum with a sticky overflow flag on a valid/ready output.
module product_accumulator #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic             ovf;
    logic             ovf_next;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_next;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] sum_next;
    logic             sum_ovf_q;
    logic             sum_ovf_next;

    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   acc_sum;
    logic             beat;

    assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign acc_sum  = {1'b0, acc} + prod_ext;
    assign beat     = in_valid && (state == ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            ovf       <= ovf_next;
            remaining <= remaining_next;
            sum_q     <= sum_next;
            sum_ovf_q <= sum_ovf_next;
        end
    end

    // The result register is loaded only on entry to DONE, so the last result
    // survives the return to IDLE and a later restart that clears acc.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        ovf_next       = ovf;
        remaining_next = remaining;
        sum_next       = sum_q;
        sum_ovf_next   = sum_ovf_q;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_next = '0;
                    ovf_next = 1'b0;
                    if (len == '0) begin
                        state_next   = DONE;
                        sum_next     = '0;
                        sum_ovf_next = 1'b0;
                    end else begin
                        state_next     = ACCUM;
                        remaining_next = len;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_next       = acc_sum[ACC_W-1:0];
                    ovf_next       = ovf | acc_sum[ACC_W];
                    remaining_next = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_next   = DONE;
                        sum_next     = acc_sum[ACC_W-1:0];
                        sum_ovf_next = ovf | acc_sum[ACC_W];
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = sum_q;
    assign out_ovf   = sum_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: directed scenarios plus randomized transactions checked
// against an arithmetic model, on a 24-bit and a 17-bit accumulator instance.
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        out_ready;

    logic        in_ready_a;
    logic        out_valid_a;
    logic [23:0] out_sum_a;
    logic        out_ovf_a;
    logic        busy_a;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [16:0] out_sum_b;
    logic        out_ovf_b;
    logic        busy_b;

    int n_checks;
    int n_pass;

    product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_prod   (in_prod),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_sum   (out_sum_a),
        .out_ovf   (out_ovf_a),
        .busy      (busy_a)
    );

    product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_prod   (in_prod),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_sum   (out_sum_b),
        .out_ovf   (out_ovf_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_txn(input int l);
        start = 1'b1;
        len   = 8'(l);
        tick();
        start = 1'b0;
        len   = 8'd0;
    endtask

    task automatic send_beat(input int p);
        in_valid = 1'b1;
        in_prod  = 16'(p);
        tick();
        in_valid = 1'b0;
        in_prod  = 16'd0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready_a, out_valid_a, busy_a, out_ovf_a} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {in_ready_a, out_valid_a, busy_a, out_ovf_a});
        else n_pass++;
        n_checks++;
        if (out_sum_a !== 24'd0)
            $display("FAIL reset_sum: got %0d expected 0", out_sum_a);
        else n_pass++;
    endtask

    task automatic test_basic();
        // in_valid while idle must be ignored
        send_beat(999);
        n_checks++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b0)
            $display("FAIL idle_ignore: got busy=%b in_ready=%b expected 0 0", busy_a, in_ready_a);
        else n_pass++;
        begin_txn(3);
        n_checks++;
        if (in_ready_a !== 1'b1 || busy_a !== 1'b1)
            $display("FAIL basic_start: got in_ready=%b busy=%b expected 1 1", in_ready_a, busy_a);
        else n_pass++;
        send_beat(100);
        send_beat(200);
        n_checks++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL basic_mid: got out_valid=%b busy=%b expected 0 1", out_valid_a, busy_a);
        else n_pass++;
        send_beat(300);
        n_checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 24'd600 || out_ovf_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL basic_sum: got v=%b sum=%0d ovf=%b busy=%b expected 1 600 0 1",
                     out_valid_a, out_sum_a, out_ovf_a, busy_a);
        else n_pass++;
        handshake();
    endtask

    task automatic test_bubbles();
        begin_txn(4);
        send_beat(65025);
        send_beat(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0)
                $display("FAIL bubble_hold: got in_ready=%b out_valid=%b expected 1 0", in_ready_a, out_valid_a);
            else n_pass++;
        end
        send_beat(0);
        tick();
        send_beat(65025);
        n_checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 24'd130051 || out_ovf_a !== 1'b0)
            $display("FAIL bubble_sum: got v=%b sum=%0d ovf=%b expected 1 130051 0",
                     out_valid_a, out_sum_a, out_ovf_a);
        else n_pass++;
        handshake();
    endtask

    task automatic test_overflow();
        begin_txn(3);
        for (int i = 0; i < 3; i++) send_beat(65025);
        n_checks++;
        if (out_valid_b !== 1'b1 || out_sum_b !== 17'd64003 || out_ovf_b !== 1'b1)
            $display("FAIL ovf_17: got v=%b sum=%0d ovf=%b expected 1 64003 1",
                     out_valid_b, out_sum_b, out_ovf_b);
        else n_pass++;
        n_checks++;
        if (out_sum_a !== 24'd195075 || out_ovf_a !== 1'b0)
            $display("FAIL ovf_24: got sum=%0d ovf=%b expected 195075 0", out_sum_a, out_ovf_a);
        else n_pass++;
        handshake();
    endtask

    task automatic test_backpressure();
        begin_txn(3);
        send_beat(100);
        send_beat(200);
        send_beat(300);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd5;
            tick();
            n_checks++;
            if (out_valid_a !== 1'b1 || out_sum_a !== 24'd600 || out_ovf_a !== 1'b0)
                $display("FAIL bp_hold: got v=%b sum=%0d ovf=%b expected 1 600 0",
                         out_valid_a, out_sum_a, out_ovf_a);
            else n_pass++;
        end
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        len       = 8'd0;
        n_checks++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b0)
            $display("FAIL bp_release: got v=%b busy=%b in_ready=%b expected 0 0 0",
                     out_valid_a, busy_a, in_ready_a);
        else n_pass++;
        tick();
        n_checks++;
        if (busy_a !== 1'b0 || out_sum_a !== 24'd600 || out_ovf_a !== 1'b0)
            $display("FAIL bp_idle_keep: got busy=%b sum=%0d ovf=%b expected 0 600 0",
                     busy_a, out_sum_a, out_ovf_a);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        begin_txn(0);
        n_checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 24'd0 || out_ovf_a !== 1'b0)
            $display("FAIL zero_len: got v=%b sum=%0d ovf=%b expected 1 0 0",
                     out_valid_a, out_sum_a, out_ovf_a);
        else n_pass++;
        send_beat(1234);
        n_checks++;
        if (in_ready_a !== 1'b0 || out_sum_a !== 24'd0 || out_valid_a !== 1'b1)
            $display("FAIL zero_len_ignore: got in_ready=%b sum=%0d v=%b expected 0 0 1",
                     in_ready_a, out_sum_a, out_valid_a);
        else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid();
        begin_txn(4);
        send_beat(500);
        send_beat(700);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || out_sum_a !== 24'd0 || busy_a !== 1'b0)
            $display("FAIL reset_mid: got in_ready=%b v=%b sum=%0d busy=%b expected 0 0 0 0",
                     in_ready_a, out_valid_a, out_sum_a, busy_a);
        else n_pass++;
        begin_txn(1);
        send_beat(9);
        n_checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 24'd9 || out_ovf_a !== 1'b0)
            $display("FAIL reset_restart: got v=%b sum=%0d ovf=%b expected 1 9 0",
                     out_valid_a, out_sum_a, out_ovf_a);
        else n_pass++;
        handshake();
    endtask

    task automatic test_random();
        longint total;
        int     l;
        int     p;
        for (int t = 0; t < 24; t++) begin
            l = (t == 5) ? 255 : int'($urandom_range(0, 9));
            total = 0;
            begin_txn(l);
            for (int i = 0; i < l; i++) begin
                int gap;
                gap = (t == 5) ? 0 : int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) tick();
                if (i == 0 || gap != 0) begin
                    n_checks++;
                    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0)
                        $display("FAIL rand_accum t=%0d: got in_ready=%b v=%b expected 1 0",
                                 t, in_ready_a, out_valid_a);
                    else n_pass++;
                end
                p = int'($urandom_range(0, 255)) * int'($urandom_range(0, 255));
                if ((t % 4) == 3) p = 65025;
                total += p;
                send_beat(p);
            end
            n_checks++;
            if (out_valid_a !== 1'b1 || out_sum_a !== 24'(total) || out_ovf_a !== ((total >> 24) != 0))
                $display("FAIL rand_sum24 t=%0d: got v=%b sum=%0d ovf=%b expected 1 %0d %0b",
                         t, out_valid_a, out_sum_a, out_ovf_a, 24'(total), (total >> 24) != 0);
            else n_pass++;
            n_checks++;
            if (out_valid_b !== 1'b1 || out_sum_b !== 17'(total) || out_ovf_b !== ((total >> 17) != 0))
                $display("FAIL rand_sum17 t=%0d: got v=%b sum=%0d ovf=%b expected 1 %0d %0b",
                         t, out_valid_b, out_sum_b, out_ovf_b, 17'(total), (total >> 17) != 0);
            else n_pass++;
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) tick();
            handshake();
            n_checks++;
            if (out_valid_a !== 1'b0 || busy_a !== 1'b0)
                $display("FAIL rand_release t=%0d: got v=%b busy=%b expected 0 0", t, out_valid_a, busy_a);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_prod   = 16'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_bubbles();
        test_overflow();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
